// File: rtl/hilo_pipe_pkg.sv
// Shared widths and constants for the HI/LO write pipeline.
package hilo_pipe_pkg;

  localparam int REG_W = 32;

  typedef logic [REG_W-1:0] reg_bus_t;

  localparam reg_bus_t ZERO_WORD     = '0;
  localparam logic     RST_ENABLE    = 1'b1;
  localparam logic     WRITE_ENABLE  = 1'b1;
  localparam logic     WRITE_DISABLE = 1'b0;
  localparam logic     STOP          = 1'b1;

endpackage

// File: rtl/hilo_stage_reg.sv
// One pipeline latch carrying a HI/LO write request (enable + two data words).
// Priority: rst > flush > bubble > hold > load. Cleared and bubble contents
// carry zero data so downstream forwarding taps never see stale words.
module hilo_stage_reg
  import hilo_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  input  logic     bubble,
  input  logic     hold,
  input  logic     wHiLo_i,
  input  reg_bus_t hi_i,
  input  reg_bus_t lo_i,
  output logic     wHiLo_o,
  output reg_bus_t hi_o,
  output reg_bus_t lo_o
);

  logic     wHiLo_q, wHiLo_d;
  reg_bus_t hi_q, hi_d;
  reg_bus_t lo_q, lo_d;

  // Next-state selection in priority order.
  always_comb begin
    wHiLo_d = wHiLo_i;
    hi_d    = hi_i;
    lo_d    = lo_i;
    if (flush || bubble) begin
      wHiLo_d = WRITE_DISABLE;
      hi_d    = ZERO_WORD;
      lo_d    = ZERO_WORD;
    end else if (hold) begin
      wHiLo_d = wHiLo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // Latch register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wHiLo_q <= WRITE_DISABLE;
      hi_q    <= ZERO_WORD;
      lo_q    <= ZERO_WORD;
    end else begin
      wHiLo_q <= wHiLo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign wHiLo_o = wHiLo_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: rtl/hilo_pipe.sv
// HI/LO write pipeline: EX/MEM latch, MEM/WB latch, then the architectural
// HI/LO register. Both latches are exposed as registered forwarding taps.
module hilo_pipe
  import hilo_pipe_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     ex_wHiLo,
  input  reg_bus_t ex_hiData,
  input  reg_bus_t ex_loData,
  input  logic     ex_stall,
  input  logic     mem_stall,
  input  logic     flush,
  output logic     mem_wHiLo_o,
  output reg_bus_t mem_hiData_o,
  output reg_bus_t mem_loData_o,
  output logic     wb_wHiLo_o,
  output reg_bus_t wb_hiData_o,
  output reg_bus_t wb_loData_o,
  output reg_bus_t hiData_o,
  output reg_bus_t loData_o
);

  logic     ex_bubble, ex_hold;
  reg_bus_t hi_q, hi_d;
  reg_bus_t lo_q, lo_d;

  // EX stalled alone sends a bubble forward; both stalled freezes EX/MEM.
  // MEM/WB never holds: a MEM stall always inserts a bubble into WB.
  assign ex_bubble = (ex_stall == STOP) && (mem_stall != STOP);
  assign ex_hold   = (ex_stall == STOP) && (mem_stall == STOP);

  hilo_stage_reg u_ex_mem (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bubble  (ex_bubble),
    .hold    (ex_hold),
    .wHiLo_i (ex_wHiLo),
    .hi_i    (ex_hiData),
    .lo_i    (ex_loData),
    .wHiLo_o (mem_wHiLo_o),
    .hi_o    (mem_hiData_o),
    .lo_o    (mem_loData_o)
  );

  hilo_stage_reg u_mem_wb (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .bubble  (mem_stall == STOP),
    .hold    (1'b0),
    .wHiLo_i (mem_wHiLo_o),
    .hi_i    (mem_hiData_o),
    .lo_i    (mem_loData_o),
    .wHiLo_o (wb_wHiLo_o),
    .hi_o    (wb_hiData_o),
    .lo_o    (wb_loData_o)
  );

  // A write sitting in WB commits regardless of stall or flush.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_wHiLo_o == WRITE_ENABLE) begin
      hi_d = wb_hiData_o;
      lo_d = wb_loData_o;
    end
  end

  // Architectural HI/LO register; reset overrides any pending commit.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      hi_q <= ZERO_WORD;
      lo_q <= ZERO_WORD;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hiData_o = hi_q;
  assign loData_o = lo_q;

endmodule

// File: tb/tb_hilo_pipe.sv
// Directed bench for hilo_pipe: inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_hilo_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_wHiLo;
  logic [31:0] ex_hiData, ex_loData;
  logic        ex_stall, mem_stall, flush;
  logic        mem_wHiLo_o, wb_wHiLo_o;
  logic [31:0] mem_hiData_o, mem_loData_o, wb_hiData_o, wb_loData_o;
  logic [31:0] hiData_o, loData_o;

  int total = 0;
  int bad   = 0;

  hilo_pipe dut (
    .clk          (clk),
    .rst          (rst),
    .ex_wHiLo     (ex_wHiLo),
    .ex_hiData    (ex_hiData),
    .ex_loData    (ex_loData),
    .ex_stall     (ex_stall),
    .mem_stall    (mem_stall),
    .flush        (flush),
    .mem_wHiLo_o  (mem_wHiLo_o),
    .mem_hiData_o (mem_hiData_o),
    .mem_loData_o (mem_loData_o),
    .wb_wHiLo_o   (wb_wHiLo_o),
    .wb_hiData_o  (wb_hiData_o),
    .wb_loData_o  (wb_loData_o),
    .hiData_o     (hiData_o),
    .loData_o     (loData_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic w, input logic [31:0] hi, input logic [31:0] lo,
                     input logic es, input logic ms, input logic fl, input logic r);
    ex_wHiLo  = w;
    ex_hiData = hi;
    ex_loData = lo;
    ex_stall  = es;
    mem_stall = ms;
    flush     = fl;
    rst       = r;
  endtask

  task automatic test_reset();
    drv(1'b1, 32'hDEADBEEF, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    total++; if ({mem_wHiLo_o, mem_hiData_o, mem_loData_o} !== 65'h0) begin bad++;
      $display("FAIL reset_mem got %b/%h/%h want 0", mem_wHiLo_o, mem_hiData_o, mem_loData_o); end
    total++; if ({wb_wHiLo_o, wb_hiData_o, wb_loData_o} !== 65'h0) begin bad++;
      $display("FAIL reset_wb got %b/%h/%h want 0", wb_wHiLo_o, wb_hiData_o, wb_loData_o); end
    total++; if ({hiData_o, loData_o} !== 64'h0) begin bad++;
      $display("FAIL reset_hilo got %h/%h want 0", hiData_o, loData_o); end
  endtask

  task automatic test_basic();
    drv(1'b1, 32'h11111111, 32'h22222222, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if ({mem_wHiLo_o, mem_hiData_o, mem_loData_o} !== {1'b1, 32'h11111111, 32'h22222222}) begin bad++;
      $display("FAIL basic_mem got %b/%h/%h want 1/11111111/22222222", mem_wHiLo_o, mem_hiData_o, mem_loData_o); end
    total++; if (wb_wHiLo_o !== 1'b0) begin bad++;
      $display("FAIL basic_wb_early got %b want 0", wb_wHiLo_o); end
    tick();
    total++; if ({wb_wHiLo_o, wb_hiData_o, wb_loData_o} !== {1'b1, 32'h11111111, 32'h22222222}) begin bad++;
      $display("FAIL basic_wb got %b/%h/%h want 1/11111111/22222222", wb_wHiLo_o, wb_hiData_o, wb_loData_o); end
    total++; if (hiData_o !== 32'h0) begin bad++;
      $display("FAIL basic_hi_early got %h want 0", hiData_o); end
    tick();
    total++; if ({hiData_o, loData_o} !== {32'h11111111, 32'h22222222}) begin bad++;
      $display("FAIL basic_commit got %h/%h want 11111111/22222222", hiData_o, loData_o); end
    total++; if (mem_wHiLo_o !== 1'b0 || mem_hiData_o !== 32'h0) begin bad++;
      $display("FAIL basic_mem_idle got %b/%h want 0/0", mem_wHiLo_o, mem_hiData_o); end
  endtask

  task automatic test_back_to_back();
    drv(1'b1, 32'hA, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'hB, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'hC, 32'hC0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (hiData_o !== 32'hA) begin bad++;
      $display("FAIL b2b_a got %h want a", hiData_o); end
    tick();
    total++; if (hiData_o !== 32'hB) begin bad++;
      $display("FAIL b2b_b got %h want b", hiData_o); end
    tick();
    total++; if ({hiData_o, loData_o} !== {32'hC, 32'hC0}) begin bad++;
      $display("FAIL b2b_c got %h/%h want c/c0", hiData_o, loData_o); end
    tick();
    total++; if (hiData_o !== 32'hC) begin bad++;
      $display("FAIL b2b_final got %h want c", hiData_o); end
  endtask

  task automatic test_stall();
    drv(1'b1, 32'h5, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({mem_wHiLo_o, mem_hiData_o, mem_loData_o} !== {1'b1, 32'h5, 32'h55}) begin bad++;
        $display("FAIL stall_hold[%0d] got %b/%h/%h want 1/5/55", i, mem_wHiLo_o, mem_hiData_o, mem_loData_o); end
      total++; if (wb_wHiLo_o !== 1'b0 || hiData_o !== 32'hC) begin bad++;
        $display("FAIL stall_wb[%0d] got wb=%b hi=%h want 0/c", i, wb_wHiLo_o, hiData_o); end
    end
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if ({wb_wHiLo_o, wb_hiData_o, wb_loData_o} !== {1'b1, 32'h5, 32'h55}) begin bad++;
      $display("FAIL stall_rel_wb got %b/%h/%h want 1/5/55", wb_wHiLo_o, wb_hiData_o, wb_loData_o); end
    total++; if (mem_wHiLo_o !== 1'b0 || hiData_o !== 32'hC) begin bad++;
      $display("FAIL stall_rel_mem got mem=%b hi=%h want 0/c", mem_wHiLo_o, hiData_o); end
    tick();
    total++; if ({hiData_o, loData_o} !== {32'h5, 32'h55}) begin bad++;
      $display("FAIL stall_commit got %h/%h want 5/55", hiData_o, loData_o); end
    total++; if (wb_wHiLo_o !== 1'b0) begin bad++;
      $display("FAIL stall_once got wb=%b want 0", wb_wHiLo_o); end
  endtask

  task automatic test_bubble();
    drv(1'b1, 32'h6, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'hE, 32'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if ({mem_wHiLo_o, mem_hiData_o, mem_loData_o} !== 65'h0) begin bad++;
      $display("FAIL bubble_mem got %b/%h/%h want 0/0/0", mem_wHiLo_o, mem_hiData_o, mem_loData_o); end
    total++; if ({wb_wHiLo_o, wb_hiData_o} !== {1'b1, 32'h6}) begin bad++;
      $display("FAIL bubble_wb got %b/%h want 1/6", wb_wHiLo_o, wb_hiData_o); end
    tick();
    total++; if (hiData_o !== 32'h6) begin bad++;
      $display("FAIL bubble_commit got %h want 6", hiData_o); end
  endtask

  task automatic test_flush();
    drv(1'b1, 32'h7, 32'h70, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'h8, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'h9, 32'h90, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b1, 32'hF, 32'hF0, 1'b0, 1'b0, 1'b1, 1'b0);
    total++; if ({hiData_o, wb_hiData_o, mem_hiData_o} !== {32'h7, 32'h8, 32'h9}) begin bad++;
      $display("FAIL flush_setup got hi=%h wb=%h mem=%h want 7/8/9", hiData_o, wb_hiData_o, mem_hiData_o); end
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if ({hiData_o, loData_o} !== {32'h8, 32'h80}) begin bad++;
      $display("FAIL flush_commit got %h/%h want 8/80", hiData_o, loData_o); end
    total++; if ({mem_wHiLo_o, mem_hiData_o, mem_loData_o} !== 65'h0) begin bad++;
      $display("FAIL flush_mem got %b/%h/%h want 0", mem_wHiLo_o, mem_hiData_o, mem_loData_o); end
    total++; if ({wb_wHiLo_o, wb_hiData_o, wb_loData_o} !== 65'h0) begin bad++;
      $display("FAIL flush_wb got %b/%h/%h want 0", wb_wHiLo_o, wb_hiData_o, wb_loData_o); end
    tick();
    tick();
    total++; if (hiData_o !== 32'h8) begin bad++;
      $display("FAIL flush_discard got %h want 8", hiData_o); end
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 32'h33, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if ({wb_wHiLo_o, wb_hiData_o} !== {1'b1, 32'h33}) begin bad++;
      $display("FAIL rstmid_setup got %b/%h want 1/33", wb_wHiLo_o, wb_hiData_o); end
    drv(1'b1, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drv(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    total++; if ({hiData_o, loData_o} !== 64'h0) begin bad++;
      $display("FAIL rstmid_hilo got %h/%h want 0/0", hiData_o, loData_o); end
    total++; if (wb_wHiLo_o !== 1'b0 || mem_wHiLo_o !== 1'b0) begin bad++;
      $display("FAIL rstmid_latches got wb=%b mem=%b want 0/0", wb_wHiLo_o, mem_wHiLo_o); end
    tick();
    tick();
    total++; if ({hiData_o, loData_o} !== 64'h0) begin bad++;
      $display("FAIL rstmid_lost got %h/%h want 0/0", hiData_o, loData_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_pipe.md
HILO_PIPE -- requirements
Module: hilo_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high (`RstEnable`).
REQ-003 SHALL have ports ex_wHiLo (input, 1 bit), ex_hiData (input, `RegBus`) and ex_loData (input, `RegBus`): the HI/LO write request produced by the execute stage.
REQ-004 SHALL have ports ex_stall (input, 1 bit) and mem_stall (input, 1 bit): hold requests for the EX/MEM and MEM/WB boundaries.
REQ-005 SHALL have port flush, input, 1 bit: pipeline flush (exception).
REQ-006 SHALL have ports mem_wHiLo_o (output, 1 bit), mem_hiData_o (output, `RegBus`) and mem_loData_o (output, `RegBus`): the EX/MEM latch contents, used as the forwarding tap.
REQ-007 SHALL have ports wb_wHiLo_o (output, 1 bit), wb_hiData_o (output, `RegBus`) and wb_loData_o (output, `RegBus`): the MEM/WB latch contents, used as the forwarding tap.
REQ-008 SHALL have ports hiData_o (output, `RegBus`) and loData_o (output, `RegBus`): the architectural HI and LO values.

Function
REQ-009 SHALL implement three registered stages: EX/MEM latch, MEM/WB latch, and the HI/LO architectural register.
REQ-010 EX/MEM latch update, priority highest first:
- flush: clear;
- ex_stall=1 and mem_stall=0: load bubble (wHiLo=0, data=`ZeroWord`);
- ex_stall=1 and mem_stall=1: hold;
- otherwise: load ex_wHiLo, ex_hiData, ex_loData.
REQ-011 MEM/WB latch update, priority highest first:
- flush: clear;
- mem_stall=1: load bubble;
- otherwise: load the EX/MEM latch contents.
REQ-012 HI/LO register SHALL load wb_hiData_o and wb_loData_o on every edge where wb_wHiLo_o=1, regardless of stall or flush.
REQ-013 hiData_o and loData_o SHALL be direct register outputs; a write becomes visible 1 cycle after it enters WB, i.e. 3 edges after EX with no stalls.
REQ-014 Bubble and cleared latches SHALL carry `ZeroWord` on both data fields, so the taps never expose stale data while wHiLo=0.
REQ-015 Flush SHALL discard writes in EX/MEM and MEM/WB but SHALL NOT alter committed HI/LO; a write already in WB at the flush edge commits.
REQ-016 Back-to-back writes SHALL commit in program order; the last WB write wins, with no coalescing.
REQ-017 When ex_stall=1 and mem_stall=1 for N cycles, an EX/MEM write SHALL be held N cycles and SHALL then proceed exactly once.
REQ-018 All taps (REQ-006, REQ-007) SHALL be registered; no combinational path from ex_* to any output.

Reset
REQ-019 When rst=1 at an edge, both latches SHALL clear (wHiLo=0, data=`ZeroWord`) and HI/LO SHALL become `ZeroWord`.
REQ-020 rst SHALL take priority over flush, stall and any pending commit, including a write present in WB.
REQ-021 On the first edge after rst deasserts, REQ-010 to REQ-012 apply normally.

Structure
REQ-022 `RegBus`, `ZeroWord`, `RstEnable`, `WriteEnable`, `WriteDisable` and `Stop` SHALL come from the shared defines.v; no new widths are introduced.
REQ-023 SHALL use one sub-module, hilo_stage_reg, instantiated twice for the EX/MEM and MEM/WB latches.
- hilo_stage_reg ports: clk, rst, flush, bubble, hold, wHiLo/hi/lo in, wHiLo/hi/lo out.
- HI/LO register is inline in hilo_pipe.

Verification
REQ-024 Reset then idle -> all outputs 0.
REQ-025 Basic commit: at edge 1 drive ex_wHiLo=1, hi=0x11111111, lo=0x22222222, no stalls ->
- mem taps show the write after edge 1;
- wb taps show it after edge 2;
- hiData_o=0x11111111 and loData_o=0x22222222 after edge 3.
REQ-026 Back-to-back writes: hi=0xA, then 0xB, then 0xC on consecutive cycles -> hiData_o steps A, B, C on consecutive cycles; final value 0xC.
REQ-027 Stalls: write hi=0x5 with ex_stall=1 and mem_stall=1 held for 3 cycles, then release ->
- mem tap holds for 3 cycles;
- write commits exactly once, 2 edges after release;
- a second case with ex_stall=1 and mem_stall=0 loads a bubble, shown as mem_wHiLo_o=0.
REQ-028 Flush: HI=0x7 committed, writes 0x8 in WB and 0x9 in MEM, flush asserted -> hiData_o becomes 0x8, 0x9 is discarded, and both latches clear.
REQ-029 Reset mid-flight: rst asserted while a write is in WB -> HI and LO are 0 after the edge and the write is lost.
